pipe_reg_chain: RTL and testbench
=================================

# pipe_reg_chain

Parametrised elastic register chain: DEPTH stages of WIDTH-bit registers with per-stage valid bits, valid/ready handshaking on both ends, bubble collapsing, flush and an occupancy count. It is the generalised successor of the team's single-bit synchronous-reset D flip-flop. It serves as the standard delay/retiming element between datapath blocks that need backpressure.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, number of register stages (≥1)
- RESET_VAL, 0, WIDTH-bit value loaded into every data register on reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all stored entries
- in_valid  in  1  upstream presents in_data
- in_ready  out  1  chain accepts in_data this cycle
- in_data  in  WIDTH  input word
- out_valid  out  1  stage DEPTH-1 holds a valid word
- out_ready  in  1  downstream accepts out_data this cycle
- out_data  out  WIDTH  data register of stage DEPTH-1 (registered, no comb path from in_data)
- count  out  $clog2(DEPTH+1)  number of valid stages

## Operation
- State: per stage i (0..DEPTH-1), v[i] (1 bit) and d[i] (WIDTH bits). Stage 0 is nearest the input.
- Stage advance terms, evaluated combinationally each cycle:
  - adv[DEPTH-1] = v[DEPTH-1] & out_ready
  - adv[i] = v[i] & (~v[i+1] | adv[i+1])
- Bubble collapsing: a valid word moves forward whenever the next stage is empty or is itself advancing.
- in_ready = ~flush & (~v[0] | adv[0]).
- Accept: the input is accepted when in_valid & in_ready. On accept, d[0] <= in_data and v[0] <= 1.
- Stage i>0 load: d[i] <= d[i-1] and v[i] <= 1 when adv[i-1]. Otherwise v[i] <= 0 if adv[i]; else it holds.
- Data registers load only on a transfer into the stage. When a stage empties, its data holds its old value and is don't-care.
- out_valid = v[DEPTH-1]; out_data = d[DEPTH-1]; out_data is stable while out_valid & ~out_ready.
- count = popcount(v), computed combinationally from v.
- Flush:
  - All v[i] <= 0 on the next edge. Data registers are unchanged.
  - in_ready is 0 during the flush cycle, so no word is accepted.
  - out_valid & out_ready in the flush cycle still counts as a delivered transfer.
- rst has priority over flush and over every transfer. It sets all v <= 0 and all d <= RESET_VAL.
- Reset values: in_ready 1 (after the reset edge), out_valid 0, out_data RESET_VAL, count 0.
- DEPTH=1 degenerates to a single skid-free register: in_ready = ~v[0] | out_ready.
- Out-of-range inputs: in_data is ignored when in_valid=0. in_valid may deassert without a handshake; the chain does not require it to be held.

## Timing
- Latency: a word accepted at edge N appears on out_data/out_valid after edge N+DEPTH-1. That is DEPTH cycles from the accept cycle to the first cycle it is visible at the output, assuming no stall.
- Throughput: 1 word/cycle sustained with out_ready held high.
- Full: count=DEPTH with out_ready=0 gives in_ready=0. With out_ready=1, a simultaneous accept and deliver is legal and count stays at DEPTH.
- Empty: count=0 gives out_valid=0.
- count changes by −1, 0 or +1 per cycle, or drops to 0 on flush/rst.
- Combinational path out_ready → in_ready is ripple through DEPTH adv terms. This is acceptable for DEPTH≤16; above that, the integrator inserts a skid.

## Structure
- Sub-module pipe_reg_stage holds one stage: a v/d register pair with load, clear, sync reset and RESET_VAL. It is instantiated DEPTH times via generate.
- Shared package pipe_pkg contains:
  - the count width function clog2p1(DEPTH)
  - the default RESET_VAL constant
- The adv chain, in_ready, popcount and flush gating stay in the top module.

## Test plan
- Reset: assert rst for 2 cycles with random inputs → out_valid=0, count=0, out_data=RESET_VAL, in_ready=1 after release.
- Streaming, DEPTH=4, out_ready=1: feed 0x01..0x08 back-to-back → 0x01 visible 3 edges after its accept edge, then one word per cycle in order; count stays 4 during steady state.
- Backpressure, out_ready=0: accept 0x10..0x13 → in_ready drops after the 4th accept, count=4. Raise out_ready for one cycle → 0x10 delivered, one new word accepted in the same cycle, count=4.
- Bubble collapse: accept 0xA0, idle 2 cycles, accept 0xA1 with out_ready=0 → both words sit in stages 3 and 2 with no gap. Then deliver in order A0, A1 on consecutive cycles.
- Flush: fill 3 entries, assert flush together with in_valid=1 → in_ready=0 that cycle, next cycle count=0 and out_valid=0, and the flushed words never appear.
- Reset mid-operation: chain full with out_ready toggling, assert rst for 1 cycle → next cycle count=0, out_data=RESET_VAL, no stale word delivered afterwards.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic register chain.
package pipe_pkg;

  localparam int DEFAULT_RESET_VAL = 0;

  // Bits needed to hold a count of 0..n inclusive.
  function automatic int clog2p1(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One chain stage: valid bit plus data register with load/clear and sync reset.
module pipe_reg_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] nxt,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  // A load always wins over clear: an advancing stage that is refilled stays valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      d <= RESET_VAL;
    end else if (load) begin
      v <= 1'b1;
      d <= nxt;
    end else if (clear) begin
      v <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic DEPTH-stage register chain with valid/ready on both ends,
// bubble collapsing, flush and an occupancy count.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [clog2p1(DEPTH)-1:0]   count
);

  localparam int CW = clog2p1(DEPTH);

  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0]            adv;
  logic [DEPTH-1:0]            load;
  logic [DEPTH-1:0]            clear;
  logic [DEPTH-1:0][WIDTH-1:0] d;
  logic [DEPTH-1:0][WIDTH-1:0] nxt;
  logic                        accept;

  // Advance terms ripple back from the output so a word moves into any
  // stage that is empty or being vacated in the same cycle.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = v[DEPTH-1] & out_ready;
    for (int i = DEPTH - 2; i >= 0; i--)
      adv[i] = v[i] & (~v[i+1] | adv[i+1]);
  end

  assign in_ready = ~flush & (~v[0] | adv[0]);
  assign accept   = in_valid & in_ready;

  // Flush blocks every load so data registers keep their contents.
  always_comb begin
    load  = '0;
    clear = '0;
    for (int i = 0; i < DEPTH; i++) begin
      load[i]  = (i == 0) ? accept : (~flush & adv[i-1]);
      clear[i] = flush | adv[i];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign nxt[i] = in_data;
    end else begin : g_body
      assign nxt[i] = d[i-1];
    end

    pipe_reg_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .load  (load[i]),
      .clear (clear[i]),
      .nxt   (nxt[i]),
      .v     (v[i]),
      .d     (d[i])
    );
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++)
      count = count + CW'(v[i]);
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain (WIDTH=8, DEPTH=4, RESET_VAL=0x5A).
module tb_pipe_reg_chain;

  localparam int               WIDTH = 8;
  localparam int               DEPTH = 4;
  localparam logic [WIDTH-1:0] RV    = 8'h5A;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       count;

  int total = 0;
  int bad   = 0;

  pipe_reg_chain #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (RV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drv(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with random inputs
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drv(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      cyc();
    end
    rst = 1'b0;
    drv(0, 8'h00, 0, 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_count",     32'(count),     0);
    chk("rst_out_data",  32'(out_data),  32'(RV));
    chk("rst_in_ready",  32'(in_ready),  1);

    // Streaming 0x01..0x08 with out_ready high
    for (int c = 0; c < 12; c++) begin
      drv(c < 8, 8'(c + 1), 1, 0);
      if (c < 8) chk("str_in_ready", 32'(in_ready), 1);
      cyc();
      #1;
      if (c >= 3 && c <= 10) begin
        chk("str_out_valid", 32'(out_valid), 1);
        chk("str_out_data",  32'(out_data),  32'(c - 2));
      end
      if (c == 2) chk("str_latency_not_yet", 32'(out_valid), 0);
      if (c >= 3 && c <= 7) chk("str_count_full", 32'(count), 4);
    end
    chk("str_drained", 32'(count), 0);

    // Backpressure: fill with 0x10..0x13, out_ready low
    for (int c = 0; c < 4; c++) begin
      drv(1, 8'(8'h10 + c), 0, 0);
      chk("bp_in_ready_fill", 32'(in_ready), 1);
      cyc();
    end
    drv(1, 8'h14, 0, 0);
    chk("bp_count_full", 32'(count), 4);
    chk("bp_in_ready_low", 32'(in_ready), 0);
    chk("bp_head", 32'(out_data), 32'h10);
    cyc();
    drv(1, 8'h14, 0, 0);
    chk("bp_hold", 32'(out_data), 32'h10);
    drv(1, 8'h14, 1, 0);
    chk("bp_in_ready_pass", 32'(in_ready), 1);
    cyc();
    drv(0, 8'h00, 1, 0);
    chk("bp_count_after", 32'(count), 4);
    for (int c = 0; c < 4; c++) begin
      chk("bp_drain_valid", 32'(out_valid), 1);
      chk("bp_drain_data",  32'(out_data),  32'(8'h11 + c));
      cyc();
      #1;
    end
    chk("bp_empty", 32'(out_valid), 0);

    // Bubble collapse: A0, two idle cycles, A1, then let A1 catch up
    drv(1, 8'hA0, 0, 0);
    cyc();
    drv(0, 8'h00, 0, 0);
    cyc();
    cyc();
    drv(1, 8'hA1, 0, 0);
    chk("bub_in_ready", 32'(in_ready), 1);
    cyc();
    drv(0, 8'h00, 0, 0);
    cyc();
    cyc();
    cyc();
    chk("bub_count", 32'(count), 2);
    chk("bub_head", 32'(out_data), 32'hA0);
    chk("bub_stage2", 32'(dut.d[2]), 32'hA1);
    chk("bub_v", 32'(dut.v), 32'b1100);
    drv(0, 8'h00, 1, 0);
    cyc();
    #1;
    chk("bub_second_valid", 32'(out_valid), 1);
    chk("bub_second_data",  32'(out_data),  32'hA1);
    cyc();
    #1;
    chk("bub_done", 32'(out_valid), 0);

    // Flush with in_valid asserted
    for (int c = 0; c < 3; c++) begin
      drv(1, 8'(8'hB0 + c), 0, 0);
      cyc();
    end
    drv(1, 8'hB3, 0, 1);
    chk("fl_count_before", 32'(count), 3);
    chk("fl_in_ready", 32'(in_ready), 0);
    cyc();
    drv(0, 8'h00, 1, 0);
    chk("fl_count", 32'(count), 0);
    chk("fl_out_valid", 32'(out_valid), 0);
    for (int c = 0; c < 5; c++) begin
      cyc();
      #1;
      chk("fl_no_ghost", 32'(out_valid), 0);
    end

    // Reset mid-operation with out_ready toggling
    for (int c = 0; c < 4; c++) begin
      drv(1, 8'(8'hC0 + c), 0, 0);
      cyc();
    end
    for (int c = 0; c < 4; c++) begin
      drv(1, 8'(8'hC4 + c), c[0] == 1'b0, 0);
      chk("rm_count_full", 32'(count), 4);
      cyc();
    end
    rst = 1'b1;
    drv(1, 8'hEE, 1, 0);
    cyc();
    rst = 1'b0;
    drv(0, 8'h00, 1, 0);
    chk("rm_count", 32'(count), 0);
    chk("rm_out_data", 32'(out_data), 32'(RV));
    chk("rm_out_valid", 32'(out_valid), 0);
    for (int c = 0; c < 4; c++) begin
      cyc();
      #1;
      chk("rm_no_stale", 32'(out_valid), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
